apb_req_bridge: RTL and testbench
=================================

# apb_req_bridge

Parametrised APB4 requester that turns a simple valid/ready command stream into APB transfers across `NUM_SLAVES` peripherals. It decodes each address to one `psel` line and runs the SETUP/ACCESS sequence, honouring `pready` wait states and `pslverr`. It also enforces a wait-state timeout and returns one response per command. It replaces the single-peripheral bridge in the APB subsystem and sits between the test/CPU-side command source and the peripheral array.

## Interface
- `ADDR_WIDTH`, 32, APB address width
- `DATA_WIDTH`, 32, APB data width (8, 16 or 32)
- `STRB_WIDTH`, `DATA_WIDTH/8`, write strobe width
- `NUM_SLAVES`, 4, number of peripherals (1..16)
- `WIN_BITS`, 12, log2 of each peripheral's address window
- `TIMEOUT`, 16, maximum ACCESS cycles with `pready` low before abort (≥1)

Ports:
- `pclk` in 1: clock. Single clock domain; reset is synchronous and active-high.
- `preset` in 1: synchronous reset, active-high.
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: command accepted when high with `cmd_valid` at posedge
- `cmd_addr` in `ADDR_WIDTH`: byte address
- `cmd_write` in 1: 1 = write, 0 = read
- `cmd_wdata` in `DATA_WIDTH`: write data
- `cmd_strb` in `STRB_WIDTH`: write strobes
- `cmd_prot` in 3: protection attributes
- `rsp_valid` out 1: one-cycle response pulse
- `rsp_rdata` out `DATA_WIDTH`: read data (0 for writes and errors)
- `rsp_err` out 1: slave error, decode error or timeout
- `rsp_timeout` out 1: error caused by timeout
- `paddr` out `ADDR_WIDTH`, `pwrite` out 1, `pwdata` out `DATA_WIDTH`, `pstrb` out `STRB_WIDTH`, `pprot` out 3: APB request
- `psel` out `NUM_SLAVES`: one-hot select
- `penable` out 1: ACCESS phase
- `prdata` in `NUM_SLAVES*DATA_WIDTH`: slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `pready` in `NUM_SLAVES`, `pslverr` in `NUM_SLAVES`: per-slave completion and error

## Operation
- States: IDLE, SETUP, ACCESS, DERR.
- `cmd_ready` = (state == IDLE). There is no command buffering.
- Decode: `idx = cmd_addr[WIN_BITS +: clog2(NUM_SLAVES)]`. The decode is legal when `idx < NUM_SLAVES` and all address bits above the index field are 0. When `NUM_SLAVES==1`, only the upper-bits check applies.
- IDLE, command accepted, legal decode: register addr/write/wdata/prot/idx, go to SETUP. `pstrb` = `cmd_strb` for writes and is forced to 0 for reads.
- IDLE, command accepted, illegal decode: go to DERR. No APB activity occurs.
- DERR: next state is IDLE. The response is `rsp_err=1`, `rsp_timeout=0`, `rsp_rdata=0`.
- SETUP: `psel[idx]=1`, `penable=0`. Next state is ACCESS unconditionally. Clear the timeout counter.
- ACCESS: `psel[idx]=1`, `penable=1`. Only `pready[idx]`, `pslverr[idx]` and `prdata[idx]` are observed; other slaves' inputs are ignored.
  - `pready[idx]=1`: transfer completes and the next state is IDLE. Response: `rsp_err=pslverr[idx]`. `rsp_rdata` is `prdata[idx]` for a read with no error, otherwise 0.
  - `pready[idx]=0`: increment the counter. When the counter reaches `TIMEOUT`, abort: next state IDLE, `psel`/`penable` drop, response `rsp_err=1`, `rsp_timeout=1`.
- `paddr`, `pwrite`, `pwdata`, `pstrb` and `pprot` are stable from SETUP through the end of ACCESS. In IDLE they hold their last values.
- Reset in any state: the next state is IDLE, the counter clears, and the aborted command gets no response.

## Timing
- Reset values: `cmd_ready=0` during reset and 1 the cycle after it; `psel=0`, `penable=0`, all APB outputs 0, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `rsp_timeout=0`.
- Command accepted at edge T: `psel` rises after T (SETUP), `penable` rises after T+1 (ACCESS).
- With zero wait states the transfer completes at edge T+2. After that edge `rsp_valid=1` for exactly one cycle, `psel=0`, `penable=0`, and `cmd_ready=1`.
- Each wait state adds one cycle. Minimum issue interval is 3 cycles per transfer.
- Decode error: accepted at T, `rsp_valid` is high in the cycle after T+1, with no `psel`.
- Timeout: `pready` low on `TIMEOUT` consecutive ACCESS edges. The abort takes effect at the `TIMEOUT`-th edge, and `rsp_valid` is high in the following cycle.
- `pready` and a timeout on the same edge: `pready` wins, and the transfer completes normally.
- All outputs are registered; nothing combinational goes from APB inputs to outputs.

## Test plan
- Reset, then write 0xA5A5_0001, strb 0xF, to 0x0000_1004 with slave 1 at zero wait. Expect `psel=4'b0010` for 2 cycles, `penable` for 1, `pwrite=1`, `pstrb=0xF`, then `rsp_valid` with `rsp_err=0` 3 cycles after acceptance.
- Read 0x0000_3010 while slave 3 inserts 2 wait states and returns 0xDEAD_BEEF. Expect ACCESS to last 3 cycles, `pstrb=0`, `rsp_rdata=0xDEAD_BEEF`, and `rsp_valid` 5 cycles after acceptance.
- Read 0x0001_0000 (upper bits nonzero). Expect no `psel`, `rsp_err=1`, `rsp_timeout=0`, `rsp_rdata=0`.
- Slave 0 holds `pready` low with `TIMEOUT=16`. Expect abort after 16 ACCESS cycles, then `rsp_err=1` and `rsp_timeout=1`. Then issue a zero-wait write and expect normal completion.
- Back-to-back: 4 commands with `cmd_valid` held high, alternating slaves 0 and 2. Expect accepts exactly every 3 cycles, 4 responses in order, and only the addressed slave's `pready`/`prdata` sampled.
- Assert `preset` for 1 cycle during ACCESS of a waited read. Expect `psel`/`penable` = 0 the next cycle, no `rsp_valid`, and `cmd_ready=1` after reset is released.

Source files
------------

// File: rtl/apb_req_bridge.sv
// APB4 requester: turns a valid/ready command stream into APB transfers on one of
// NUM_SLAVES peripherals, with address decode, wait-state timeout and one response per command.
module apb_req_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_SLAVES = 4,
  parameter int WIN_BITS   = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic                             cmd_write,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [STRB_WIDTH-1:0]            cmd_strb,
  input  logic [2:0]                       cmd_prot,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  output logic [STRB_WIDTH-1:0]            pstrb,
  output logic [2:0]                       pprot,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);

  localparam int IDX_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 0;
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_e;

  state_e                  state_q;
  logic                    cmd_ready_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        count_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [STRB_WIDTH-1:0]   pstrb_q;
  logic [2:0]              pprot_q;
  logic [NUM_SLAVES-1:0]   psel_q;
  logic                    penable_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    rsp_timeout_q;

  logic [IDX_W-1:0]        cmd_idx;
  logic                    cmd_legal;
  logic [NUM_SLAVES-1:0]   cmd_onehot;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    sel_ready;
  logic                    sel_err;

  // With a single peripheral there is no index field; only the window check remains.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cmd_idx    = '0;
    cmd_onehot = '0;
    if (IDX_BITS > 0) cmd_idx = cmd_addr[WIN_BITS +: IDX_W];
    cmd_legal = ((cmd_addr >> (WIN_BITS + IDX_BITS)) == '0) && (int'(cmd_idx) < NUM_SLAVES);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(cmd_idx) == i) cmd_onehot[i] = 1'b1;
    end
  end

  // Only the addressed slave's completion, error and data are ever looked at.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(idx_q) == i) begin
        sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ready = pready[i];
        sel_err   = pslverr[i];
      end
    end
  end

  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (preset) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      idx_q         <= '0;
      count_q       <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (cmd_legal) begin
              paddr_q  <= cmd_addr;
              pwrite_q <= cmd_write;
              pwdata_q <= cmd_wdata;
              pstrb_q  <= cmd_write ? cmd_strb : '0;
              pprot_q  <= cmd_prot;
              idx_q    <= cmd_idx;
              psel_q   <= cmd_onehot;
              state_q  <= SETUP;
            end else begin
              state_q <= DERR;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          count_q   <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // A ready on the edge that would otherwise time out still completes normally.
          if (sel_ready) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= sel_err;
            rsp_rdata_q <= (!pwrite_q && !sel_err) ? sel_rdata : '0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else if (count_q == CNT_LAST) begin
            psel_q        <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            cmd_ready_q   <= 1'b1;
            state_q       <= IDLE;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        DERR: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Bench for apb_req_bridge: vector table plus hand-written back-to-back and reset sequences,
// with responses checked against a scoreboard queue filled at command acceptance.
module tb_apb_req_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int NS = 4;
  localparam int TO = 16;

  logic              pclk = 1'b0;
  logic              preset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [AW-1:0]     cmd_addr;
  logic              cmd_write;
  logic [DW-1:0]     cmd_wdata;
  logic [SW-1:0]     cmd_strb;
  logic [2:0]        cmd_prot;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [AW-1:0]     paddr;
  logic              pwrite;
  logic [DW-1:0]     pwdata;
  logic [SW-1:0]     pstrb;
  logic [2:0]        pprot;
  logic [NS-1:0]     psel;
  logic              penable;
  wire  [NS*DW-1:0]  prdata;
  wire  [NS-1:0]     pready;
  wire  [NS-1:0]     pslverr;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wait_n;
    logic        slverr;
    logic [31:0] rdata;
    logic [3:0]  exp_psel;
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic        to;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t        sb[$];
  vec_t        vecs[12];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          wait_cfg = 0;
  logic        slverr_cfg = 1'b0;
  logic [31:0] rdata_cfg = '0;

  apb_req_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
    .NUM_SLAVES(NS), .WIN_BITS(12), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    cyc     <= cyc + 1;
    acc_cyc <= penable ? acc_cyc + 1 : 0;
  end

  // Selected slave follows the configured wait/error/data; the others drive values that
  // would corrupt the result if the bridge looked at them.
  for (genvar i = 0; i < NS; i++) begin : g_slv
    assign pready[i]           = psel[i] ? (penable && (acc_cyc >= wait_cfg)) : 1'b1;
    assign pslverr[i]          = psel[i] ? slverr_cfg : 1'b1;
    assign prdata[i*DW +: DW]  = psel[i] ? rdata_cfg : (32'hBAD0_0000 | 32'(i));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr, input bit push, input rsp_t exp);
    int n;
    @(negedge pclk);
    cmd_addr = a; cmd_write = w; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("accept_ready", 64'(cmd_ready), 64'd1);
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    if (push) sb.push_back(exp);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   n;
    rsp_t e;
    wait_cfg = v.wait_n; slverr_cfg = v.slverr; rdata_cfg = v.rdata;
    e.err = v.exp_err; e.to = v.exp_to; e.rdata = v.exp_rdata;
    issue(v.addr, v.write, v.wdata, v.strb, v.prot, 1'b1, e);
    check({tag, "_setup_psel"}, 64'(psel), 64'(v.exp_psel));
    check({tag, "_setup_penable"}, 64'(penable), 64'd0);
    if (v.exp_psel != 4'd0) begin
      check({tag, "_paddr"}, 64'(paddr), 64'(v.addr));
      check({tag, "_pwrite"}, 64'(pwrite), 64'(v.write));
      check({tag, "_pwdata"}, 64'(pwdata), 64'(v.wdata));
      check({tag, "_pstrb"}, 64'(pstrb), v.write ? 64'(v.strb) : 64'd0);
      check({tag, "_pprot"}, 64'(pprot), 64'(v.prot));
    end
    n = 0;
    do begin
      @(posedge pclk);
      #1;
      n++;
      if (n == 1 && v.exp_psel != 4'd0) begin
        check({tag, "_access_penable"}, 64'(penable), 64'd1);
        check({tag, "_access_psel"}, 64'(psel), 64'(v.exp_psel));
        check({tag, "_access_paddr"}, 64'(paddr), 64'(v.addr));
      end
    end while (rsp_valid !== 1'b1 && n < 40);
    check({tag, "_latency"}, 64'(n), 64'(v.exp_lat));
    check({tag, "_done_psel"}, 64'(psel), 64'd0);
    check({tag, "_done_penable"}, 64'(penable), 64'd0);
    check({tag, "_done_ready"}, 64'(cmd_ready), 64'd1);
    @(posedge pclk);
    #1;
    check({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] b2b_addr[4];
    int          acc_at[4];
    int          n;
    rsp_t        e;

    // addr, write, wdata, strb, prot, wait, slverr, rdata, exp_psel, exp_err, exp_to, exp_rdata, exp_lat
    vecs[0]  = '{32'h0000_1004, 1'b1, 32'hA5A5_0001, 4'hF, 3'd0, 0,    1'b0, 32'h0,          4'b0010, 1'b0, 1'b0, 32'h0,          2};
    vecs[1]  = '{32'h0000_3010, 1'b0, 32'h0,         4'hF, 3'd2, 2,    1'b0, 32'hDEAD_BEEF,  4'b1000, 1'b0, 1'b0, 32'hDEAD_BEEF,  4};
    vecs[2]  = '{32'h0001_0000, 1'b0, 32'h0,         4'h0, 3'd0, 0,    1'b0, 32'h1111_2222,  4'b0000, 1'b1, 1'b0, 32'h0,          1};
    vecs[3]  = '{32'h0000_0008, 1'b0, 32'h0,         4'h0, 3'd1, 1000, 1'b0, 32'h1111_1111,  4'b0001, 1'b1, 1'b1, 32'h0,          17};
    vecs[4]  = '{32'h0000_2000, 1'b1, 32'h1234_5678, 4'hF, 3'd0, 0,    1'b0, 32'h0,          4'b0100, 1'b0, 1'b0, 32'h0,          2};
    vecs[5]  = '{32'h0000_2FFC, 1'b0, 32'h0,         4'h0, 3'd0, 1,    1'b1, 32'hCAFE_0001,  4'b0100, 1'b1, 1'b0, 32'h0,          3};
    vecs[6]  = '{32'h0000_1000, 1'b1, 32'h55AA_55AA, 4'h5, 3'd4, 0,    1'b1, 32'h0,          4'b0010, 1'b1, 1'b0, 32'h0,          2};
    vecs[7]  = '{32'h0000_0000, 1'b0, 32'h0,         4'h0, 3'd0, 15,   1'b0, 32'h1234_5678,  4'b0001, 1'b0, 1'b0, 32'h1234_5678,  17};
    vecs[8]  = '{32'h8000_3000, 1'b0, 32'h0,         4'h0, 3'd0, 0,    1'b0, 32'h0,          4'b0000, 1'b1, 1'b0, 32'h0,          1};
    vecs[9]  = '{32'h0000_4000, 1'b1, 32'h7777_7777, 4'hF, 3'd0, 0,    1'b0, 32'h0,          4'b0000, 1'b1, 1'b0, 32'h0,          1};
    vecs[10] = '{32'h0000_3FFC, 1'b1, 32'h0BAD_F00D, 4'h3, 3'd7, 3,    1'b0, 32'h0,          4'b1000, 1'b0, 1'b0, 32'h0,          5};
    vecs[11] = '{32'h0000_1FFF, 1'b0, 32'h0,         4'h0, 3'd0, 0,    1'b0, 32'h00C0_FFEE,  4'b0010, 1'b0, 1'b0, 32'h00C0_FFEE,  2};

    preset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pstrb", 64'(pstrb), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'({rsp_err, rsp_timeout}), 64'd0);
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk);
    #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back reads with cmd_valid held high, alternating slaves 0 and 2.
    wait_cfg = 0; slverr_cfg = 1'b0; rdata_cfg = 32'h0BAD_CAFE;
    b2b_addr[0] = 32'h0000_0010; b2b_addr[1] = 32'h0000_2020;
    b2b_addr[2] = 32'h0000_0030; b2b_addr[3] = 32'h0000_2040;
    e.err = 1'b0; e.to = 1'b0; e.rdata = 32'h0BAD_CAFE;
    @(negedge pclk);
    cmd_addr = b2b_addr[0]; cmd_write = 1'b0; cmd_strb = 4'hF; cmd_prot = 3'd0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
        @(negedge pclk);
        n++;
      end
      check("b2b_ready", 64'(cmd_ready), 64'd1);
      @(posedge pclk);
      #1;
      acc_at[k] = cyc;
      sb.push_back(e);
      check("b2b_psel", 64'(psel), (k % 2 == 0) ? 64'b0001 : 64'b0100);
      if (k < 3) cmd_addr = b2b_addr[k+1];
      else cmd_valid = 1'b0;
    end
    for (int k = 1; k < 4; k++) check("b2b_interval", 64'(acc_at[k] - acc_at[k-1]), 64'd3);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("b2b_drain", 64'(sb.size()), 64'd0);

    // Reset during ACCESS of a waited read: the aborted read must not respond.
    wait_cfg = 8; rdata_cfg = 32'h5555_AAAA;
    issue(32'h0000_2000, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, e);
    @(posedge pclk);
    #1;
    check("rstacc_in_access", 64'(penable), 64'd1);
    @(negedge pclk);
    preset = 1'b1;
    @(posedge pclk);
    #1;
    check("rstacc_psel", 64'(psel), 64'd0);
    check("rstacc_penable", 64'(penable), 64'd0);
    check("rstacc_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstacc_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk);
    #1;
    check("rstacc_ready_after", 64'(cmd_ready), 64'd1);
    repeat (12) @(posedge pclk);
    run_vec(vecs[4], "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
